// File: rtl/round_judge_if.sv
// Handshake and result bundle between the round judge and its environment.
// The round controller (testbench or game logic) is the master; round_judge is the slave.
interface round_judge_if #(
    parameter int N_PLAYERS = 2,
    parameter int CNT_W     = 16
);
    localparam int IDW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

    logic                 start;
    logic                 abort;
    logic [N_PLAYERS-1:0] ans_valid;
    logic [N_PLAYERS-1:0] ans_ok;
    logic                 res_ack;
    logic                 busy;
    logic [N_PLAYERS-1:0] lockout;
    logic                 res_valid;
    logic [1:0]           res_code;
    logic [N_PLAYERS-1:0] win_mask;
    logic [IDW-1:0]       win_id;
    logic [CNT_W-1:0]     elapsed;

    modport master (
        output start, abort, ans_valid, ans_ok, res_ack,
        input  busy, lockout, res_valid, res_code, win_mask, win_id, elapsed
    );

    modport slave (
        input  start, abort, ans_valid, ans_ok, res_ack,
        output busy, lockout, res_valid, res_code, win_mask, win_id, elapsed
    );
endinterface

// File: rtl/round_judge.sv
// Timed answer-round judge: first correct answer wins, simultaneous correct answers draw,
// wrong answers lock the player out; the result is held until the HP manager acknowledges it.
module round_judge #(
    parameter int N_PLAYERS = 2,
    parameter int TIMEOUT   = 1000,
    parameter int CNT_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    round_judge_if.slave   bus
);
    localparam int IDW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OPEN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] CODE_TIMEOUT = 2'b00;
    localparam logic [1:0] CODE_SINGLE  = 2'b01;
    localparam logic [1:0] CODE_WRONG   = 2'b10;
    localparam logic [1:0] CODE_DRAW    = 2'b11;

    logic [1:0]           state_q,     state_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic                 busy_q,      busy_d;
    logic [N_PLAYERS-1:0] lockout_q,   lockout_d;
    logic                 res_valid_q, res_valid_d;
    logic [1:0]           res_code_q,  res_code_d;
    logic [N_PLAYERS-1:0] win_mask_q,  win_mask_d;
    logic [IDW-1:0]       win_id_q,    win_id_d;
    logic [CNT_W-1:0]     elapsed_q,   elapsed_d;

    logic [N_PLAYERS-1:0] eligible;
    logic [N_PLAYERS-1:0] correct_v;
    logic [N_PLAYERS-1:0] wrong_v;
    logic [IDW-1:0]       first_id;
    logic                 single_hit;

    always_comb begin
        eligible   = bus.ans_valid & ~lockout_q;
        correct_v  = eligible & bus.ans_ok;
        wrong_v    = eligible & ~bus.ans_ok;
        single_hit = ((correct_v & (correct_v - N_PLAYERS'(1))) == '0);
        // Scan downward so the lowest set index is the last one written.
        first_id = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (correct_v[i]) first_id = IDW'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        lockout_d   = lockout_q;
        res_valid_d = res_valid_q;
        res_code_d  = res_code_q;
        win_mask_d  = win_mask_q;
        win_id_d    = win_id_q;
        elapsed_d   = elapsed_q;

        case (state_q)
            ST_IDLE: begin
                res_valid_d = 1'b0;
                if (bus.start) begin
                    state_d   = ST_OPEN;
                    cnt_d     = '0;
                    lockout_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_OPEN: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    lockout_d = '0;
                end else if ((correct_v != '0) || (&(lockout_q | wrong_v)) ||
                             (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    res_valid_d = 1'b1;
                    lockout_d   = lockout_q | wrong_v;
                    elapsed_d   = cnt_q;
                    win_mask_d  = correct_v;
                    win_id_d    = first_id;
                    if (correct_v != '0)
                        res_code_d = single_hit ? CODE_SINGLE : CODE_DRAW;
                    else if (&(lockout_q | wrong_v))
                        res_code_d = CODE_WRONG;
                    else
                        res_code_d = CODE_TIMEOUT;
                end else begin
                    lockout_d = lockout_q | wrong_v;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // A START arriving with the ACK is deliberately dropped.
                if (bus.abort || bus.res_ack) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            lockout_q   <= '0;
            res_valid_q <= 1'b0;
            res_code_q  <= '0;
            win_mask_q  <= '0;
            win_id_q    <= '0;
            elapsed_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            lockout_q   <= lockout_d;
            res_valid_q <= res_valid_d;
            res_code_q  <= res_code_d;
            win_mask_q  <= win_mask_d;
            win_id_q    <= win_id_d;
            elapsed_q   <= elapsed_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.lockout   = lockout_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_code  = res_code_q;
    assign bus.win_mask  = win_mask_q;
    assign bus.win_id    = win_id_q;
    assign bus.elapsed   = elapsed_q;
endmodule

// File: tb/tb_round_judge.sv
// Directed and random rounds for a 4-player, 8-cycle judge, checked every cycle
// against a behavioural model of the round rules.
module tb_round_judge;
    localparam int NP = 4;
    localparam int TO = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    round_judge_if #(.N_PLAYERS(NP), .CNT_W(CW)) bus ();

    round_judge #(.N_PLAYERS(NP), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: round phase plus the visible result record.
    int          m_phase;
    int          m_cnt;
    logic        m_busy;
    logic [3:0]  m_lock;
    logic        m_valid;
    logic [1:0]  m_code;
    logic [3:0]  m_mask;
    int          m_id;
    int          m_elapsed;

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_busy = 0; m_lock = 0; m_valid = 0;
        m_code = 0; m_mask = 0; m_id = 0; m_elapsed = 0;
    endtask

    task automatic model_step(input logic s, input logic a, input logic [3:0] v,
                              input logic [3:0] k, input logic ack);
        logic [3:0] c, w;
        c = v & ~m_lock & k;
        w = v & ~m_lock & ~k;
        if (m_phase == 0) begin
            m_valid = 0;
            if (s) begin m_phase = 1; m_cnt = 0; m_lock = 0; m_busy = 1; end
        end else if (m_phase == 1) begin
            if (a) begin
                m_phase = 0; m_busy = 0; m_lock = 0;
            end else if (c != 0 || (m_lock | w) == 4'hF || m_cnt == TO - 1) begin
                m_phase = 2; m_busy = 0; m_valid = 1;
                m_lock = m_lock | w; m_elapsed = m_cnt; m_mask = c; m_id = 0;
                for (int i = 0; i < NP; i++) if (c[i]) begin m_id = i; break; end
                if (c != 0) m_code = ($countones(c) == 1) ? 2'b01 : 2'b11;
                else if (m_lock == 4'hF) m_code = 2'b10;
                else m_code = 2'b00;
            end else begin
                m_lock = m_lock | w;
                m_cnt = m_cnt + 1;
            end
        end else begin
            if (a || ack) begin m_phase = 0; m_valid = 0; end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check("busy",      32'(bus.busy),      32'(m_busy));
        check("lockout",   32'(bus.lockout),   32'(m_lock));
        check("res_valid", 32'(bus.res_valid), 32'(m_valid));
        check("res_code",  32'(bus.res_code),  32'(m_code));
        check("win_mask",  32'(bus.win_mask),  32'(m_mask));
        check("win_id",    32'(bus.win_id),    32'(m_id));
        check("elapsed",   32'(bus.elapsed),   32'(m_elapsed));
    endtask

    task automatic apply_stimulus(input logic s, input logic a, input logic [3:0] v,
                                  input logic [3:0] k, input logic ack);
        bus.start = s; bus.abort = a; bus.ans_valid = v; bus.ans_ok = k; bus.res_ack = ack;
        @(posedge clk);
        model_step(s, a, v, k, ack);
        #1;
        check_output();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 4'h0, 4'h0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.abort = 0; bus.ans_valid = 0; bus.ans_ok = 0; bus.res_ack = 0;
        model_reset();
        #12;
        check_output();
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] single winner");
        apply_stimulus(1, 0, 4'h0, 4'h0, 0);
        idle_cycles(3);
        apply_stimulus(0, 0, 4'b0010, 4'b0010, 0);
        check("t1_code", 32'(bus.res_code), 32'h1);
        check("t1_id",   32'(bus.win_id),   32'h1);
        check("t1_elap", 32'(bus.elapsed),  32'h3);
        apply_stimulus(1, 0, 4'b0001, 4'b0001, 0);
        idle_cycles(1);
        apply_stimulus(0, 0, 4'h0, 4'h0, 1);
        check("t1_after_ack", 32'(bus.res_valid), 32'h0);

        $display("[TB] draw");
        apply_stimulus(1, 0, 4'h0, 4'h0, 0);
        apply_stimulus(0, 0, 4'b1101, 4'b0101, 0);
        check("t2_code", 32'(bus.res_code), 32'h3);
        check("t2_mask", 32'(bus.win_mask), 32'h5);
        apply_stimulus(0, 0, 4'h0, 4'h0, 1);

        $display("[TB] lockout");
        apply_stimulus(1, 0, 4'h0, 4'h0, 0);
        idle_cycles(1);
        apply_stimulus(0, 0, 4'b0001, 4'b0000, 0);
        check("t3_lock", 32'(bus.lockout), 32'h1);
        apply_stimulus(0, 0, 4'b0001, 4'b0001, 0);
        apply_stimulus(0, 0, 4'b0110, 4'b0000, 0);
        apply_stimulus(0, 0, 4'b1000, 4'b0000, 0);
        check("t3_code", 32'(bus.res_code), 32'h2);
        check("t3_elap", 32'(bus.elapsed),  32'h4);
        check("t3_lockall", 32'(bus.lockout), 32'hF);
        apply_stimulus(0, 0, 4'h0, 4'h0, 1);

        $display("[TB] timeout and last-cycle answer");
        apply_stimulus(1, 0, 4'h0, 4'h0, 0);
        idle_cycles(TO);
        check("t4_code", 32'(bus.res_code), 32'h0);
        check("t4_elap", 32'(bus.elapsed),  32'(TO - 1));
        apply_stimulus(0, 0, 4'h0, 4'h0, 1);
        apply_stimulus(1, 0, 4'h0, 4'h0, 0);
        idle_cycles(TO - 1);
        apply_stimulus(0, 0, 4'b0010, 4'b0010, 0);
        check("t4b_code", 32'(bus.res_code), 32'h1);
        check("t4b_elap", 32'(bus.elapsed),  32'(TO - 1));
        apply_stimulus(0, 0, 4'h0, 4'h0, 1);

        $display("[TB] abort and async reset");
        apply_stimulus(1, 0, 4'h0, 4'h0, 0);
        apply_stimulus(0, 0, 4'b0100, 4'b0000, 0);
        idle_cycles(1);
        apply_stimulus(0, 1, 4'h0, 4'h0, 0);
        check("t5_busy", 32'(bus.busy), 32'h0);
        apply_stimulus(1, 0, 4'h0, 4'h0, 0);
        apply_stimulus(0, 0, 4'b0001, 4'b0000, 0);
        idle_cycles(5);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_output();
        @(posedge clk); #1;
        check_output();
        rst = 1'b0;
        idle_cycles(2);

        $display("[TB] start with ack");
        apply_stimulus(1, 0, 4'h0, 4'h0, 0);
        apply_stimulus(0, 0, 4'b0001, 4'b0001, 0);
        apply_stimulus(1, 0, 4'h0, 4'h0, 1);
        check("t6_busy0", 32'(bus.busy), 32'h0);
        apply_stimulus(1, 0, 4'h0, 4'h0, 0);
        check("t6_busy1", 32'(bus.busy), 32'h1);
        idle_cycles(1);
        apply_stimulus(0, 0, 4'b0100, 4'b0100, 0);
        check("t6_elap", 32'(bus.elapsed), 32'h1);
        apply_stimulus(0, 0, 4'h0, 4'h0, 1);

        $display("[TB] random rounds");
        for (int n = 0; n < 600; n++) begin
            logic s, a, ack;
            logic [3:0] v, k;
            s   = ($urandom_range(0, 99) < 25);
            a   = ($urandom_range(0, 99) < 3);
            ack = ($urandom_range(0, 99) < 30);
            v   = 4'($urandom) & 4'($urandom) & 4'($urandom);
            k   = 4'($urandom) & 4'($urandom);
            apply_stimulus(s, a, v, k, ack);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/round_judge.md
Name: round_judge

Overview:
- Parametrised successor to the two-player win/lose comparator for the factorization game.
- Opens a timed answer round for N_PLAYERS players and decides the outcome: first correct answer wins, simultaneous correct answers draw, wrong answers lock the player out, and the round ends on timeout or when every player is locked out.
- Holds the decided result for the HP manager under a valid/ack handshake, together with the winner identity and the decision time (used for speed bonus).

Parameters:
- N_PLAYERS, 2, number of players; must be >= 1.
- TIMEOUT, 1000, round length in clock cycles; must be >= 1.
- CNT_W, 16, elapsed-counter width; must satisfy 2^CNT_W > TIMEOUT.
- IDW, derived: max(1, clog2(N_PLAYERS)); not user-set.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle pulse that opens a round; honoured only in IDLE.
- ABORT  in  1  cancels the round; no result is produced.
- ANS_VALID  in  N_PLAYERS  per-player answer strobe for this cycle.
- ANS_OK  in  N_PLAYERS  per-player correctness, qualified by ANS_VALID; 1 = correct.
- RES_ACK  in  1  HP manager has consumed the result.
- BUSY  out  1  high while the round is open.
- LOCKOUT  out  N_PLAYERS  players who answered wrong in the current round.
- RES_VALID  out  1  result held and stable.
- RES_CODE  out  2  00 timeout, 01 single winner, 11 draw, 10 all players wrong.
- WIN_MASK  out  N_PLAYERS  players that answered correctly in the deciding cycle.
- WIN_ID  out  IDW  lowest set index of WIN_MASK; 0 if WIN_MASK is 0.
- ELAPSED  out  CNT_W  counter value in the deciding cycle.

Behaviour:
- Reset (asynchronous, RST high): state IDLE; BUSY, LOCKOUT, RES_VALID, RES_CODE, WIN_MASK, WIN_ID, ELAPSED and the counter all go to 0.
- States are IDLE, OPEN and DONE. All outputs are registered.
- IDLE:
  - START=1 -> OPEN next edge; counter cleared to 0; LOCKOUT cleared; BUSY=1 from that cycle.
  - Result outputs keep their previous values, but RES_VALID=0.
- OPEN, evaluated every cycle:
  - Eligible answers: E = ANS_VALID & ~LOCKOUT. Answers from locked-out players are ignored.
  - C = E & ANS_OK (correct answers); W = E & ~ANS_OK (wrong answers).
  - Decisions, highest priority first:
    - ABORT=1 -> IDLE; BUSY=0; LOCKOUT=0; no result.
    - C != 0 -> DONE. WIN_MASK=C; RES_CODE=01 if exactly one bit of C is set, else 11; WIN_ID=lowest set index of C; ELAPSED=counter.
    - (LOCKOUT | W) all ones -> DONE; RES_CODE=10; WIN_MASK=0; ELAPSED=counter.
    - counter == TIMEOUT-1 -> DONE; RES_CODE=00; WIN_MASK=0; ELAPSED=counter.
    - Otherwise: LOCKOUT |= W; counter increments; stay in OPEN.
  - A correct answer in the last cycle beats timeout. A correct answer beats wrong answers from other players in the same cycle.
  - LOCKOUT also absorbs W on the deciding edge.
- Latency: a deciding answer is sampled at edge k; RES_VALID=1 and BUSY=0 from edge k.
- DONE:
  - RES_VALID=1; all result outputs are frozen; ANS_* and START are ignored.
  - RES_ACK=1 -> IDLE next edge; RES_VALID=0.
  - START together with RES_ACK in the same cycle: START is dropped and a fresh START is required.
  - ABORT in DONE -> IDLE; RES_VALID=0.
- Counter never wraps: the maximum value reached is TIMEOUT-1.
- N_PLAYERS=1: the code cannot be 11; the player's only wrong answer yields code 10.
- RST asserted mid-round discards the round with no result. After RST release, START is needed again.

Test Plan:
- N=2, TIMEOUT=10. START; player1 correct at counter 3 -> RES_VALID next edge; RES_CODE=01, WIN_MASK=10, WIN_ID=1, ELAPSED=3. Outputs held until RES_ACK; RES_VALID=0 the cycle after ACK.
- N=4. Players 0 and 2 correct in the same cycle while player 3 is wrong -> RES_CODE=11, WIN_MASK=0101, WIN_ID=0.
- N=2. Player0 wrong at counter 1 -> LOCKOUT=01. Player0 correct at counter 2 is ignored. Player1 wrong at counter 4 -> RES_CODE=10, ELAPSED=4, LOCKOUT=11.
- TIMEOUT=5, no answers -> DONE with RES_CODE=00, ELAPSED=4. Repeat with player1 correct at counter 4 -> RES_CODE=01, ELAPSED=4.
- ABORT at counter 2 -> IDLE, no RES_VALID, LOCKOUT=0. RST pulsed at counter 6 of a new round -> all outputs 0 immediately (asynchronous).
- In DONE, START with RES_ACK in the same cycle -> IDLE, BUSY stays 0. START one cycle later -> BUSY=1, counter restarts at 0.
